fpu_issue_arbiter: RTL and testbench
====================================

// Module: fpu_issue_arbiter
// PURPOSE
//  Sequences the shared half-precision FPU datapath (hp_top) for two requesters.
//  Round-robin arbitrates operation requests and registers the operands and opcode.
//  Holds the datapath inputs stable for a fixed settle window, then captures the result and flags.
//  Returns them, tagged, through a valid/ready response port. One operation in flight at a time.
// PARAMETERS
//  NUM_BITS       16  operand/result width; must match the hp_top instance
//  SETTLE_CYCLES  1   cycles the fpu_* inputs are held before capture; >=1, 0 is an elaboration error
//  TAG_W          2   width of the requester-supplied transaction tag
// PORTS
//  clk           in   1         clock
//  reset         in   1         asynchronous reset, active-low
//  req0_valid    in   1         requester 0 has an operation
//  req0_ready    out  1         requester 0 operation accepted this cycle (with req0_valid)
//  req0_a        in   NUM_BITS  operand a
//  req0_b        in   NUM_BITS  operand b
//  req0_op       in   3         opcode, hp_top encoding ({ADD,SUB,MUL,DIV} x {RN,SR})
//  req0_tag      in   TAG_W     returned unchanged on rsp_tag
//  req1_*        -    -         identical set for requester 1
//  rsp_valid     out  1         result available
//  rsp_ready     in   1         consumer takes result
//  rsp_result    out  NUM_BITS  captured fpu_res
//  rsp_flags     out  6         captured {zero,inf,subN,Norm,QNan,SNan}
//  rsp_tag       out  TAG_W     tag of the completed operation
//  rsp_src       out  1         requester index (0/1) of the completed operation
//  fpu_src_a     out  NUM_BITS  to hp_top src_a
//  fpu_src_b     out  NUM_BITS  to hp_top src_b
//  fpu_operation out  3         to hp_top operation
//  fpu_res       in   NUM_BITS  from hp_top res_out
//  fpu_flags     in   6         from hp_top {zero,inf,subN,Norm,QNan,SNan}
//  busy          out  1         high in any state other than IDLE
// BEHAVIOUR
//  FSM with states IDLE, EXEC and RESP. Reset values:
//   - state=IDLE, last_grant=1 (requester 0 wins the first tie), counter=0.
//   - All outputs 0: no ready, no valid, fpu_* = 0, op=3'b000.
//  IDLE:
//   - grant = the sole valid requester; on a tie, the requester != last_grant.
//   - reqN_ready = grantN (combinational from the valids). It is 0 in EXEC and RESP.
//   - On accept: register a, b, op, tag and src; last_grant<=src; counter<=SETTLE_CYCLES-1; go to EXEC.
//  EXEC:
//   - fpu_src_a/fpu_src_b/fpu_operation are driven from registers, stable from the cycle after accept.
//   - The counter decrements each cycle. In the cycle where counter==0: capture fpu_res and fpu_flags, then go to RESP.
//   - Latency: accept at edge T gives rsp_valid high from edge T+SETTLE_CYCLES+1.
//  RESP:
//   - rsp_* is held constant while rsp_valid=1 && rsp_ready=0.
//   - When rsp_ready=1: go to IDLE. No new request is accepted in the same cycle (min 1 IDLE cycle between ops).
//   - Throughput: one op per SETTLE_CYCLES+2 cycles with no backpressure.
//  General rules:
//   - fpu_* keep their last operands after completion (no toggling to 0) until the next accept.
//   - An SR op consumes the RNG state present in the capture cycle. The controller does not gate or advance the RNG.
//   - Requests that are not granted are neither dropped nor latched. The requester must hold valid and its payload until ready.
//   - Asserting reset mid-EXEC or mid-RESP aborts immediately: the in-flight result is discarded and all registers return to reset values.
// TESTING
//  1. req0: a=0x3C00 b=0x4000 op=000 tag=1, SETTLE=1 -> rsp_valid at T+2, result=0x4200, flags=6'b000100, tag=1, src=0.
//  2. req0 and req1 valid in the same cycle, both held:
//     - Grants alternate 0,1,0,1.
//     - req1 MUL 0x4000*0x4000 -> 0x4400.
//     - No accept while busy=1.
//  3. rsp_ready=0 for 5 cycles -> rsp_* stable, req ready=0 throughout. Release -> IDLE for 1 cycle, then the next accept.
//  4. req1 DIV 0x3C00/0x0000 -> result 0x7C00 with inf flag=1. 0x7E00+0x3C00 -> QNan flag=1, passed unchanged.
//  5. Reset asserted in EXEC with SETTLE=3 -> async clear:
//     - No rsp_valid.
//     - After release, the first tie goes to req0.
//  6. Accept with SETTLE=4 -> fpu_* constant for 4 cycles; rsp_valid at T+5; the captured value equals fpu_res in the capture cycle.

Source files
------------

// File: rtl/fpu_issue_arbiter.sv
// Two-requester round-robin issue controller for the shared half-precision FPU.
// Holds operands for a settle window, captures result/flags, returns them tagged.
module fpu_issue_arbiter #(
  parameter int NUM_BITS      = 16,
  parameter int SETTLE_CYCLES = 1,
  parameter int TAG_W         = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [NUM_BITS-1:0] req0_a,
  input  logic [NUM_BITS-1:0] req0_b,
  input  logic [2:0]          req0_op,
  input  logic [TAG_W-1:0]    req0_tag,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [NUM_BITS-1:0] req1_a,
  input  logic [NUM_BITS-1:0] req1_b,
  input  logic [2:0]          req1_op,
  input  logic [TAG_W-1:0]    req1_tag,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [NUM_BITS-1:0] rsp_result,
  output logic [5:0]          rsp_flags,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic                rsp_src,
  output logic [NUM_BITS-1:0] fpu_src_a,
  output logic [NUM_BITS-1:0] fpu_src_b,
  output logic [2:0]          fpu_operation,
  input  logic [NUM_BITS-1:0] fpu_res,
  input  logic [5:0]          fpu_flags,
  output logic                busy
);

  localparam int CNT_W =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(SETTLE_CYCLES - 1);

  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("SETTLE_CYCLES must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_BITS-1:0] a_q, a_d;
  logic [NUM_BITS-1:0] b_q, b_d;
  logic [2:0]          op_q, op_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                src_q, src_d;
  logic [NUM_BITS-1:0] res_q, res_d;
  logic [5:0]          flg_q, flg_d;

  logic gnt0, gnt1, idle;

  // last_q==1 means requester 1 went last, so requester 0 wins a tie
  assign gnt0 = req0_valid & (~req1_valid | last_q);
  assign gnt1 = req1_valid & (~req0_valid | ~last_q);
  assign idle = (state_q == IDLE);

  assign req0_ready    = idle & gnt0;
  assign req1_ready    = idle & gnt1;
  assign busy          = ~idle;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_result    = res_q;
  assign rsp_flags     = flg_q;
  assign rsp_tag       = tag_q;
  assign rsp_src       = src_q;
  assign fpu_src_a     = a_q;
  assign fpu_src_b     = b_q;
  assign fpu_operation = op_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tag_d   = tag_q;
    src_d   = src_q;
    res_d   = res_q;
    flg_d   = flg_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0 | gnt1) begin
          src_d   = gnt1;
          last_d  = gnt1;
          a_d     = gnt1 ? req1_a   : req0_a;
          b_d     = gnt1 ? req1_b   : req0_b;
          op_d    = gnt1 ? req1_op  : req0_op;
          tag_d   = gnt1 ? req1_tag : req0_tag;
          cnt_d   = CNT_INIT;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          res_d   = fpu_res;
          flg_d   = fpu_flags;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      src_q   <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      src_q   <= src_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Bench for fpu_issue_arbiter: vector table, scoreboard, and
// hand sequences for ties, backpressure, long settle and mid-op reset.
module tb_fpu_issue_arbiter;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  // stand-in for hp_top: known answers for the listed cases
  function automatic logic [21:0] fpu_model(
    logic [15:0] a, logic [15:0] b, logic [2:0] op);
    case ({op, a, b})
      {OP_ADD, 16'h3C00, 16'h4000}: return {6'b000100, 16'h4200};
      {OP_MUL, 16'h4000, 16'h4000}: return {6'b000100, 16'h4400};
      {OP_DIV, 16'h3C00, 16'h0000}: return {6'b010000, 16'h7C00};
      {OP_ADD, 16'h7E00, 16'h3C00}: return {6'b000010, 16'h7E00};
      default: return {6'b000100, a ^ b ^ {13'b0, op}};
    endcase
  endfunction

  // ---------------- DUT 1: SETTLE_CYCLES = 1 ----------------
  logic        v0 = 0, v1 = 0, rr = 1;
  logic [15:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [2:0]  op0 = 0, op1 = 0;
  logic [1:0]  t0 = 0, t1 = 0;
  logic        r0, r1, rv, bsy, rsrc;
  logic [15:0] rres, fa, fb, fres;
  logic [5:0]  rflg, fflg;
  logic [1:0]  rtag;
  logic [2:0]  fop;

  always_comb {fflg, fres} = fpu_model(fa, fb, fop);

  fpu_issue_arbiter #(.NUM_BITS(16), .SETTLE_CYCLES(1), .TAG_W(2)) dut1 (
    .clk(clk), .reset(rst_n),
    .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0),
    .req0_op(op0), .req0_tag(t0),
    .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1),
    .req1_op(op1), .req1_tag(t1),
    .rsp_valid(rv), .rsp_ready(rr), .rsp_result(rres),
    .rsp_flags(rflg), .rsp_tag(rtag), .rsp_src(rsrc),
    .fpu_src_a(fa), .fpu_src_b(fb), .fpu_operation(fop),
    .fpu_res(fres), .fpu_flags(fflg), .busy(bsy));

  // ------- DUT 2 (SETTLE=4) and DUT 3 (SETTLE=3), shared stimulus -------
  logic        wv0 = 0, wv1 = 0, wrr = 1;
  logic [15:0] wa0 = 0, wb0 = 0, wa1 = 0, wb1 = 0;
  logic [2:0]  wop0 = 0, wop1 = 0;
  logic [1:0]  wt0 = 0, wt1 = 0;
  logic [7:0]  cyc8;
  assign cyc8 = cyc[7:0];

  logic        d2_r0, d2_r1, d2_rv, d2_bsy, d2_src;
  logic [15:0] d2_res, d2_fa, d2_fb, d2_fres;
  logic [5:0]  d2_flg, d2_fflg;
  logic [1:0]  d2_tag;
  logic [2:0]  d2_fop;
  assign d2_fres = d2_fa ^ {8'h00, cyc8};
  assign d2_fflg = {3'b000, d2_fop};

  fpu_issue_arbiter #(.NUM_BITS(16), .SETTLE_CYCLES(4), .TAG_W(2)) dut2 (
    .clk(clk), .reset(rst_n),
    .req0_valid(wv0), .req0_ready(d2_r0), .req0_a(wa0), .req0_b(wb0),
    .req0_op(wop0), .req0_tag(wt0),
    .req1_valid(wv1), .req1_ready(d2_r1), .req1_a(wa1), .req1_b(wb1),
    .req1_op(wop1), .req1_tag(wt1),
    .rsp_valid(d2_rv), .rsp_ready(wrr), .rsp_result(d2_res),
    .rsp_flags(d2_flg), .rsp_tag(d2_tag), .rsp_src(d2_src),
    .fpu_src_a(d2_fa), .fpu_src_b(d2_fb), .fpu_operation(d2_fop),
    .fpu_res(d2_fres), .fpu_flags(d2_fflg), .busy(d2_bsy));

  logic        d3_r0, d3_r1, d3_rv, d3_bsy, d3_src;
  logic [15:0] d3_res, d3_fa, d3_fb, d3_fres;
  logic [5:0]  d3_flg, d3_fflg;
  logic [1:0]  d3_tag;
  logic [2:0]  d3_fop;
  assign d3_fres = d3_fa ^ {8'h00, cyc8};
  assign d3_fflg = {3'b000, d3_fop};

  fpu_issue_arbiter #(.NUM_BITS(16), .SETTLE_CYCLES(3), .TAG_W(2)) dut3 (
    .clk(clk), .reset(rst_n),
    .req0_valid(wv0), .req0_ready(d3_r0), .req0_a(wa0), .req0_b(wb0),
    .req0_op(wop0), .req0_tag(wt0),
    .req1_valid(wv1), .req1_ready(d3_r1), .req1_a(wa1), .req1_b(wb1),
    .req1_op(wop1), .req1_tag(wt1),
    .rsp_valid(d3_rv), .rsp_ready(wrr), .rsp_result(d3_res),
    .rsp_flags(d3_flg), .rsp_tag(d3_tag), .rsp_src(d3_src),
    .fpu_src_a(d3_fa), .fpu_src_b(d3_fb), .fpu_operation(d3_fop),
    .fpu_res(d3_fres), .fpu_flags(d3_fflg), .busy(d3_bsy));

  // ---------------- scoreboard for DUT 1 ----------------
  typedef struct {
    logic [15:0] res;
    logic [5:0]  flg;
    logic [1:0]  tag;
    logic        src;
    int          acc;
  } exp_t;

  exp_t sbq[$];

  initial begin : monitor
    logic        pv, pr;
    logic [24:0] prsp;
    int          first_cyc;
    exp_t        e;
    pv = 0; pr = 0; prsp = '0; first_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rv && !pv) first_cyc = cyc;
        if (pv && !pr)
          chk("rsp_hold", {rv, rres, rflg, rtag, rsrc}, {1'b1, prsp});
        if (bsy) chk("ready_while_busy", {r0, r1}, 2'b00);
        if (rv && rr) begin
          if (sbq.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("rsp_result", rres, e.res);
            chk("rsp_flags", rflg, e.flg);
            chk("rsp_tag", rtag, e.tag);
            chk("rsp_src", rsrc, e.src);
            chk("latency", first_cyc - e.acc, 2);
          end
        end
      end
      pv = rv; pr = rr;
      prsp = {rres, rflg, rtag, rsrc};
    end
  end

  typedef struct {
    logic        s;
    logic [15:0] a, b;
    logic [2:0]  op;
    logic [1:0]  tag;
    logic [15:0] res;
    logic [5:0]  flg;
  } vec_t;

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !bsy) break;
    end
    if (sbq.size() != 0 || bsy) chk("drain_timeout", 1, 0);
  endtask

  task automatic issue(vec_t v);
    bit got;
    @(posedge clk); #1;
    if (v.s) begin
      a1 = v.a; b1 = v.b; op1 = v.op; t1 = v.tag; v1 = 1;
    end else begin
      a0 = v.a; b0 = v.b; op0 = v.op; t0 = v.tag; v0 = 1;
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (v.s ? r1 : r0) begin
        sbq.push_back('{v.res, v.flg, v.tag, v.s, cyc});
        got = 1;
      end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    v0 = 0; v1 = 0;
    drain();
  endtask

  vec_t vecs[6];
  int   gl[$];
  int   acc[$];
  exp_t e0, e1;
  int   k;
  bit   got;
  logic [7:0] c8;

  initial begin
    vecs[0] = '{0, 16'h3C00, 16'h4000, OP_ADD, 2'd1, 16'h4200, 6'b000100};
    vecs[1] = '{1, 16'h4000, 16'h4000, OP_MUL, 2'd2, 16'h4400, 6'b000100};
    vecs[2] = '{1, 16'h3C00, 16'h0000, OP_DIV, 2'd3, 16'h7C00, 6'b010000};
    vecs[3] = '{0, 16'h7E00, 16'h3C00, OP_ADD, 2'd0, 16'h7E00, 6'b000010};
    vecs[4] = '{0, 16'h1234, 16'h0F0F, OP_SUB, 2'd2, 16'h1D3A, 6'b000100};
    vecs[5] = '{1, 16'hABCD, 16'h0000, 3'b111, 2'd3, 16'hABCA, 6'b000100};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dut1_ctl", {bsy, rv, r0, r1}, 4'b0000);
    chk("rst_dut1_fpu", {fa, fb, fop}, 35'h0);
    chk("rst_dut1_rsp", {rres, rflg, rtag, rsrc}, 25'h0);
    chk("rst_dut2_ctl", {d2_bsy, d2_rv, d2_fa, d2_fop}, 21'h0);
    @(negedge clk);
    rst_n = 1;

    // table-driven single operations
    for (int i = 0; i < 6; i++) issue(vecs[i]);

    // tie: both held, grants must alternate 0,1,0,1 at full rate
    e0 = '{16'h3332, 6'b000100, 2'd1, 1'b0, 0};
    e1 = '{16'h4400, 6'b000100, 2'd2, 1'b1, 0};
    @(posedge clk); #1;
    a0 = 16'h1111; b0 = 16'h2222; op0 = OP_SUB; t0 = 2'd1; v0 = 1;
    a1 = 16'h4000; b1 = 16'h4000; op1 = OP_MUL; t1 = 2'd2; v1 = 1;
    for (int i = 0; i < 40 && gl.size() < 4; i++) begin
      @(negedge clk);
      if (r0 && r1) chk("double_grant", 1, 0);
      if (r0) begin
        e0.acc = cyc; sbq.push_back(e0); gl.push_back(0); acc.push_back(cyc);
      end else if (r1) begin
        e1.acc = cyc; sbq.push_back(e1); gl.push_back(1); acc.push_back(cyc);
      end
    end
    @(posedge clk); #1;
    v0 = 0; v1 = 0;
    if (gl.size() != 4) begin
      chk("tie_grant_count", gl.size(), 4);
    end else begin
      chk("grant_order", {gl[0][0], gl[1][0], gl[2][0], gl[3][0]}, 4'b0101);
      for (int i = 1; i < 4; i++)
        chk("tie_spacing", acc[i] - acc[i-1], 3);
    end
    drain();

    // backpressure: response held 5 cycles, req1 waiting is not accepted
    @(posedge clk); #1;
    rr = 0;
    a0 = 16'h0101; b0 = 16'h0202; op0 = OP_ADD; t0 = 2'd2; v0 = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (r0) begin
        sbq.push_back('{16'h0303, 6'b000100, 2'd2, 1'b0, cyc});
        got = 1;
      end
    end
    if (!got) chk("bp_accept_timeout", 0, 1);
    @(posedge clk); #1;
    v0 = 0;
    a1 = 16'h4000; b1 = 16'h4000; op1 = OP_MUL; t1 = 2'd1; v1 = 1;
    for (int i = 0; i < 10 && !rv; i++) @(negedge clk);
    chk("bp_rsp_valid_seen", rv, 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid_held", rv, 1);
      chk("bp_req1_blocked", r1, 0);
    end
    @(posedge clk); #1;
    rr = 1;
    @(negedge clk);
    chk("bp_handshake_no_accept", r1, 0);
    @(negedge clk);
    chk("bp_next_accept", {bsy, r1}, 2'b01);
    if (r1) sbq.push_back('{16'h4400, 6'b000100, 2'd1, 1'b1, cyc});
    @(posedge clk); #1;
    v1 = 0;
    drain();

    // long settle (dut2, SETTLE=4): operands held, capture in last cycle
    @(posedge clk); #1;
    wrr = 1;
    wa0 = 16'h5A00; wb0 = 16'h0033; wop0 = OP_MUL; wt0 = 2'd2; wv0 = 1;
    got = 0; k = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (d2_r0) begin k = cyc; got = 1; end
    end
    if (!got) chk("s4_accept_timeout", 0, 1);
    @(posedge clk); #1;
    wv0 = 0; wa0 = 16'hFFFF; wb0 = 16'hFFFF; wop0 = 3'b111;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) @(posedge clk);
      @(negedge clk);
      chk("s4_fpu_hold", {d2_fa, d2_fb, d2_fop}, {16'h5A00, 16'h0033, OP_MUL});
      chk("s4_no_valid_yet", d2_rv, 0);
    end
    @(negedge clk);
    c8 = 8'(k + 4);
    chk("s4_valid_at_T5", d2_rv, 1);
    chk("s4_result", d2_res, 16'h5A00 ^ {8'h00, c8});
    chk("s4_flags_tag_src", {d2_flg, d2_tag, d2_src}, {6'b000010, 2'd2, 1'b0});
    @(negedge clk);
    chk("s4_fpu_kept", {d2_bsy, d2_fa, d2_fop}, {1'b0, 16'h5A00, OP_MUL});
    repeat (4) @(negedge clk);

    // reset mid-EXEC (dut3, SETTLE=3)
    @(posedge clk); #1;
    wa0 = 16'h1357; wb0 = 16'h0001; wop0 = OP_ADD; wt0 = 2'd3; wv0 = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (d3_r0) got = 1;
    end
    if (!got) chk("rst_accept_timeout", 0, 1);
    @(posedge clk); #1;
    wv0 = 0;
    @(negedge clk);
    chk("rst_pre_busy", d3_bsy, 1);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("rst_async_clear", {d3_bsy, d3_rv, d3_fa, d3_fop}, 21'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", {d3_rv, d3_bsy}, 2'b00);
    end
    @(posedge clk); #1;
    wa0 = 16'h0011; wa1 = 16'h0022; wv0 = 1; wv1 = 1;
    @(negedge clk);
    chk("rst_first_tie_dut3", {d3_r0, d3_r1}, 2'b10);
    chk("rst_first_tie_dut2", {d2_r0, d2_r1}, 2'b10);
    @(posedge clk); #1;
    wv0 = 0; wv1 = 0;
    repeat (12) @(negedge clk);
    chk("end_idle", {d2_bsy, d3_bsy, bsy}, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

endmodule
